// File: rtl/gantry_pkg.sv
// Shared definitions for the parking gantry display stage.
//   - Active-low seven-segment patterns {g,f,e,d,c,b,a} for the non-numeric glyphs.
//   - 5-bit glyph codes understood by seg7_glyph: bit 4 clear selects a hex digit in
//     bits 3:0, bit 4 set selects one of the named glyphs below.
//   - Event indicator state enum.
package gantry_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;

    localparam logic [4:0] GL_BLANK = 5'h10;
    localparam logic [4:0] GL_E     = 5'h11;
    localparam logic [4:0] GL_L     = 5'h12;
    localparam logic [4:0] GL_F     = 5'h13;
    localparam logic [4:0] GL_U     = 5'h14;

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_ENTRY,
        EV_LEAVE
    } ev_state_e;

    // Glyph code for a decimal/hex digit value.
    function automatic logic [4:0] hex_code(input logic [3:0] value);
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder.
//   code : 5-bit selector; 0x00-0x0F hex digit, 0x10.. named glyph (see gantry_pkg)
//   seg  : active-low segment pattern {g,f,e,d,c,b,a}; unknown codes decode to blank
module seg7_glyph
    import gantry_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'h00:    seg = 7'b1000000;
            5'h01:    seg = 7'b1111001;
            5'h02:    seg = 7'b0100100;
            5'h03:    seg = 7'b0110000;
            5'h04:    seg = 7'b0011001;
            5'h05:    seg = 7'b0010010;
            5'h06:    seg = 7'b0000010;
            5'h07:    seg = 7'b1111000;
            5'h08:    seg = 7'b0000000;
            5'h09:    seg = 7'b0010000;
            5'h0A:    seg = 7'b0001000;
            5'h0B:    seg = 7'b0000011;
            5'h0C:    seg = 7'b1000110;
            5'h0D:    seg = 7'b0100001;
            5'h0E:    seg = 7'b0000110;
            5'h0F:    seg = 7'b0001110;
            GL_E:     seg = SEG_E;
            GL_L:     seg = SEG_L;
            GL_F:     seg = SEG_F;
            GL_U:     seg = SEG_U;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gantry_display.sv
// Parking gantry display stage: 4-digit multiplexed seven-segment driver.
//   clk, rst   : system clock, synchronous active-high reset
//   car_count  : current occupancy (unsigned)
//   enter/exit : single-cycle event pulses from the gantry FSM
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   an         : active-low one-hot digit enables, an[0] rightmost
//   full       : registered car_count >= CAPACITY
// Digit 0/1 show free spaces, digit 3 shows a timed E/L event glyph, and a blinking
// FULL banner replaces the whole frame at capacity.
module gantry_display
    import gantry_pkg::*;
#(
    parameter int unsigned CAPACITY     = 15,
    parameter int unsigned DIGIT_CYCLES = 100_000,
    parameter int unsigned EVENT_CYCLES = 100_000_000,
    parameter int unsigned BLINK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] car_count,
    input  logic       enter,
    input  logic       exit,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       full
);

    localparam int unsigned PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned HW = (EVENT_CYCLES > 1) ? $clog2(EVENT_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(EVENT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [3:0]    CAP        = 4'(CAPACITY);

    // ---------------- scan prescaler and digit index ----------------
    logic [PW-1:0] presc_q;
    logic          tick_q;
    logic [1:0]    idx_q;

    // The tick is registered so the output stage sees a clean one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (presc_q == PRESC_LAST);
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    // ---------------- event indicator FSM ----------------
    ev_state_e     ev_q;
    logic [HW-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q   <= EV_IDLE;
            hold_q <= '0;
        end else if (enter) begin
            ev_q   <= EV_ENTRY;
            hold_q <= HOLD_LOAD;
        end else if (exit) begin
            ev_q   <= EV_LEAVE;
            hold_q <= HOLD_LOAD;
        end else if (ev_q != EV_IDLE) begin
            if (hold_q == '0) begin
                ev_q <= EV_IDLE;
            end else begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    // ---------------- full flag and blink timer ----------------
    logic          full_d;
    logic          blink_q;
    logic [BW-1:0] bcnt_q;

    assign full_d = (car_count >= CAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            full <= full_d;
            if (full_d && !full) begin
                // Restart on the rising edge so the banner shows immediately.
                blink_q <= 1'b1;
                bcnt_q  <= '0;
            end else if (bcnt_q == BLINK_LAST) begin
                blink_q <= ~blink_q;
                bcnt_q  <= '0;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

    // ---------------- free spaces in BCD ----------------
    logic [3:0] free;
    logic       tens;
    logic [3:0] ones;

    always_comb begin
        free = full_d ? 4'd0 : CAP - car_count;
        tens = (free >= 4'd10);
        ones = tens ? free - 4'd10 : free;
    end

    // ---------------- frame composition ----------------
    logic [4:0] code;
    logic [6:0] glyph_seg;

    always_comb begin
        code = GL_BLANK;
        if (full) begin
            if (blink_q) begin
                unique case (idx_q)
                    2'd3:    code = GL_F;
                    2'd2:    code = GL_U;
                    2'd1:    code = GL_L;
                    2'd0:    code = GL_L;
                    default: code = GL_BLANK;
                endcase
            end
        end else begin
            unique case (idx_q)
                2'd0:    code = hex_code(ones);
                2'd1:    code = tens ? hex_code(4'd1) : GL_BLANK;
                2'd2:    code = GL_BLANK;
                2'd3: begin
                    case (ev_q)
                        EV_ENTRY: code = GL_E;
                        EV_LEAVE: code = GL_L;
                        default:  code = GL_BLANK;
                    endcase
                end
                default: code = GL_BLANK;
            endcase
        end
    end

    seg7_glyph u_glyph (
        .code (code),
        .seg  (glyph_seg)
    );

    // ---------------- output registers ----------------
    // an and seg load together from the same index, then the index moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_BLANK;
            an    <= 4'b1111;
            idx_q <= 2'd0;
        end else if (tick_q) begin
            seg   <= glyph_seg;
            an    <= ~(4'b0001 << idx_q);
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: doc/gantry_display.md
# gantry_display

Display stage downstream of the car counter in the parking gantry design. It consumes the live `car_count` and the single-cycle `enter`/`exit` pulses from the gantry FSM. It drives a 4-digit, time-multiplexed seven-segment display showing free spaces, a timed entry/leave indicator, and a blinking "FULL" banner when the car park is at capacity.

## Interface
- `CAPACITY`, 15: number of bays, 1..15.
- `DIGIT_CYCLES`, 100_000: clk cycles each digit stays enabled (1 ms at 100 MHz).
- `EVENT_CYCLES`, 100_000_000: hold time of the entry/leave indicator.
- `BLINK_CYCLES`, 50_000_000: half-period of the FULL blink.
- `clk` in 1: system clock, one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `car_count` in 4: current occupancy from the counter, unsigned.
- `enter` in 1: one-cycle pulse, car entered.
- `exit` in 1: one-cycle pulse, car left.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an` out 4: digit enables, active-low, one-hot-low; `an[0]` is the rightmost digit.
- `full` out 1: high while `car_count >= CAPACITY`.

## Operation
- **Free spaces:** `free = (car_count >= CAPACITY) ? 0 : CAPACITY - car_count`, 4-bit. Convert to BCD: `tens = (free >= 10)`, `ones = free - 10*tens`.
- **Normal frame** (not full):
  - digit0 shows `ones`.
  - digit1 shows `1` if `tens`, otherwise blank (leading-zero suppression).
  - digit2 is blank.
  - digit3 shows the event glyph: `E` in ENTRY, `L` in LEAVE, blank in IDLE.
- **Full frame:** digits 3..0 show `F`,`U`,`L`,`L` while blink phase = 1, and all blank while blink phase = 0. This frame overrides the event glyph.
- **Glyphs:**
  - `0`=1000000, `1`=1111001, `9`=0010000, `E`=0000110, `L`=1000111, `F`=0001110, `U`=1000001, blank=1111111.
  - Remaining digits use the standard active-low hex decode.
- **Event FSM** (states IDLE, ENTRY, LEAVE):
  - `enter` moves to ENTRY from any state; `exit` moves to LEAVE from any state. Either one reloads the hold counter with `EVENT_CYCLES-1`.
  - If `enter` and `exit` arrive in the same cycle, `enter` wins.
  - In ENTRY or LEAVE, the hold counter decrements each cycle. When it reaches 0 with no new pulse, the FSM returns to IDLE.
  - A pulse that arrives while the counter is running restarts the hold.
- **Blink:**
  - The counter runs freely and toggles the blink phase every `BLINK_CYCLES` cycles.
  - On the cycle `full` rises, the phase is forced to 1 and the counter is reloaded, so the banner is always visible immediately.
- **Scan:**
  - The prescaler counts 0..`DIGIT_CYCLES-1`. The terminal count produces a one-cycle tick.
  - The 2-bit digit index advances 0→1→2→3→0 on each tick.
- **Reset values:** `seg`=1111111, `an`=1111, `full`=0, digit index 0, prescaler 0, FSM IDLE, hold 0, blink phase 1, blink counter 0.
  - Reset applied mid-hold or mid-blink returns everything to these values on the next edge.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `an` and `seg` update together on the edge after the tick. A digit is never enabled with another digit's segments.
- `full` has 1 cycle of latency from `car_count`.
- The event FSM state is registered 1 cycle after the pulse. It becomes visible when digit3 is next scanned, worst case 4×`DIGIT_CYCLES`+1 cycles later.
- A `car_count` change is visible on `seg` the next time the affected digit is scanned: 1 cycle after that digit's tick.
- The first digit is enabled `DIGIT_CYCLES`+1 cycles after reset deasserts.
- The hold lasts exactly `EVENT_CYCLES` cycles from the state register change back to IDLE.

## Structure
- Shared package `gantry_pkg`: glyph constants (`SEG_BLANK`, `SEG_E`, `SEG_L`, `SEG_F`, `SEG_U`) and the event state enum (`EV_IDLE`, `EV_ENTRY`, `EV_LEAVE`).
- One sub-module, `seg7_glyph`: combinational decode from a 5-bit code (hex digit or glyph selector) to a 7-bit segment pattern.
- The top file contains the prescaler, scan index, event FSM, blink timer, BCD conversion and output registers.

## Test plan
Bench parameters: `CAPACITY`=12, `DIGIT_CYCLES`=4, `EVENT_CYCLES`=40, `BLINK_CYCLES`=20.
- **Reset:** hold `rst` for 3 cycles → `seg`=1111111, `an`=1111, `full`=0 throughout. The first `an`=1110 appears 5 cycles after release.
- **Two-digit count:** `car_count`=1 → digit0 and digit1 both show 1111001, digit2 and digit3 blank. `car_count`=3 → digit0 shows 0010000 and digit1 is blank.
- **Entry then leave:**
  - Pulse `enter` → digit3 shows 0000110 on each scan for 40 cycles, then blank.
  - Pulse `exit` at cycle 20 of the hold → digit3 switches to 1000111, and the hold runs for 40 cycles from that point.
  - Pulse `enter` and `exit` together → `E`.
- **Full:**
  - `car_count`=12 → `full`=1 after 1 cycle. Digits show F,U,L,L for 20 cycles, then blank for 20, and this repeats.
  - `car_count`=15 → free saturates at 0 and the FULL behaviour is unchanged.
  - Dropping to 11 → digit0 shows 1111001 (`1`), digit1 blank, `full`=0.
- **Reset mid-operation:** assert `rst` during an ENTRY hold and a blink-off phase → all outputs return to reset values on the next edge. The FSM is IDLE after release.
- **Scan integrity:** over 1000 random cycles, `an` is always 1111 or one-hot-low. On each tick the index advances by exactly one.
